// File: rtl/neuron_bank_rotator.sv
// neuron_bank_rotator: rotates NB single-port neuron banks between a producer
// stream (pooling output) and a consumer stream (convolution input). Tracks a
// FREE/FILL/FULL/DRAIN state per bank, drives bank addresses and write strobes,
// and hides the one-cycle RAM read latency behind a 2-entry output FIFO.
module neuron_bank_rotator #(
  parameter int NB    = 3,
  parameter int depth = 3,
  parameter int W     = 16,
  parameter int A     = 11
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [A-1:0]               frameLen,
  input  logic                       wrValid,
  output logic                       wrReady,
  input  logic [W*(1<<depth)-1:0]    wrData,
  output logic                       rdValid,
  input  logic                       rdReady,
  output logic [W*(1<<depth)-1:0]    rdData,
  input  logic                       rdKeep,
  output logic [NB*A-1:0]            bankAddr,
  output logic [NB-1:0]              bankWrite,
  output logic [NB*W*(1<<depth)-1:0] bankIn,
  input  logic [NB*W*(1<<depth)-1:0] bankOut,
  output logic [$clog2(NB+1)-1:0]    fullCount,
  output logic                       frameDone
);

  localparam int WD = W * (1 << depth);
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW = $clog2(NB + 1);

  typedef enum logic [1:0] {
    FREE  = 2'd0,
    FILL  = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } bankState_t;

  bankState_t    state     [NB];
  bankState_t    stateNext [NB];
  bankState_t    wrState;
  bankState_t    rdState;
  logic [BW-1:0] wrBank;
  logic [BW-1:0] rdBank;
  logic [A-1:0]  wrAddr;
  logic [A-1:0]  rdAddr;
  logic          wrAccept;
  logic          wrLast;
  logic          rdIssue;
  logic          rdLast;
  logic          inFlight;
  logic          lastInFlight;
  logic          keepCap;
  logic [1:0]    fifoCount;
  logic [WD-1:0] fifoHead;
  logic [WD-1:0] fifoSecond;
  logic [WD-1:0] pushData;
  logic          fifoPop;
  logic [2:0]    occupancy;
  logic [CW-1:0] fullNow;

  function automatic logic [BW-1:0] nextBank(input logic [BW-1:0] b);
    return (b == BW'(NB - 1)) ? '0 : b + BW'(1);
  endfunction

  // Select the state of the write/read banks, the read data of the bank in flight, and count occupied banks
  always_comb begin
    wrState  = FREE;
    rdState  = FREE;
    pushData = '0;
    fullNow  = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (BW'(b) == wrBank) wrState = state[b];
      if (BW'(b) == rdBank) begin
        rdState  = state[b];
        pushData = bankOut[b*WD +: WD];
      end
      if (state[b] == FULL || state[b] == DRAIN) fullNow = fullNow + CW'(1);
    end
  end

  assign wrReady  = RST_N && (wrState == FREE || wrState == FILL);
  assign wrAccept = wrValid && wrReady;
  assign wrLast   = wrAccept && (wrAddr == frameLen);

  assign rdValid   = (fifoCount != 2'd0);
  assign rdData    = fifoHead;
  assign fifoPop   = rdValid && rdReady;
  // A word popped this cycle frees a slot in time for the word issued now,
  // which keeps one word per cycle flowing with rdReady held high.
  assign occupancy = {1'b0, fifoCount} + {2'b00, inFlight} - {2'b00, fifoPop};
  // No issue while the final word of a pass is in flight: the bank is about to leave DRAIN.
  assign rdIssue   = (rdState == FULL || rdState == DRAIN) && !lastInFlight && (occupancy < 3'd2);
  assign rdLast    = rdIssue && (rdAddr == frameLen);

  assign bankIn = RST_N ? {NB{wrData}} : '0;

  // Bank state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned b = 0; b < NB; b++) state[b] <= FREE;
    end else begin
      for (int unsigned b = 0; b < NB; b++) state[b] <= stateNext[b];
    end
  end

  // Bank next-state: write fill, read drain, and release or retain after the last word lands
  always_comb begin
    for (int unsigned b = 0; b < NB; b++) begin
      stateNext[b] = state[b];
      if (wrAccept && BW'(b) == wrBank) stateNext[b] = wrLast ? FULL : FILL;
      if (rdIssue && BW'(b) == rdBank && state[b] == FULL) stateNext[b] = DRAIN;
      if (lastInFlight && BW'(b) == rdBank) stateNext[b] = keepCap ? FULL : FREE;
    end
  end

  // Bank port outputs: idle banks see address 0 and no write
  always_comb begin
    bankAddr  = '0;
    bankWrite = '0;
    for (int unsigned b = 0; b < NB; b++) begin
      if (wrAccept && BW'(b) == wrBank) begin
        bankWrite[b]        = 1'b1;
        bankAddr[b*A +: A]  = wrAddr;
      end
      if (rdIssue && BW'(b) == rdBank) bankAddr[b*A +: A] = rdAddr;
    end
  end

  // Write and read bank pointers and word addresses
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wrBank <= '0;
      wrAddr <= '0;
      rdBank <= '0;
      rdAddr <= '0;
    end else begin
      if (wrAccept) begin
        if (wrLast) begin
          wrAddr <= '0;
          wrBank <= nextBank(wrBank);
        end else begin
          wrAddr <= wrAddr + A'(1);
        end
      end
      if (rdIssue) rdAddr <= rdLast ? '0 : rdAddr + A'(1);
      if (lastInFlight && !keepCap) rdBank <= nextBank(rdBank);
    end
  end

  // Read-in-flight tracking, keep capture and end-of-pass pulse
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      inFlight     <= 1'b0;
      lastInFlight <= 1'b0;
      keepCap      <= 1'b0;
      frameDone    <= 1'b0;
    end else begin
      inFlight     <= rdIssue;
      lastInFlight <= rdLast;
      frameDone    <= rdLast;
      if (rdLast) keepCap <= rdKeep;
    end
  end

  // Two-entry output FIFO; the head register drives rdData directly
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fifoCount  <= 2'd0;
      fifoHead   <= '0;
      fifoSecond <= '0;
    end else begin
      if (inFlight && fifoPop) begin
        if (fifoCount == 2'd1) begin
          fifoHead <= pushData;
        end else begin
          fifoHead   <= fifoSecond;
          fifoSecond <= pushData;
        end
      end else if (inFlight) begin
        if (fifoCount == 2'd0) fifoHead <= pushData;
        else                   fifoSecond <= pushData;
        fifoCount <= fifoCount + 2'd1;
      end else if (fifoPop) begin
        fifoHead  <= fifoSecond;
        fifoCount <= fifoCount - 2'd1;
      end
    end
  end

  // Occupied-bank count, one cycle behind the bank states
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) fullCount <= '0;
    else        fullCount <= fullNow;
  end

endmodule

// File: tb/tb_neuron_bank_rotator.sv
// Testbench for neuron_bank_rotator: emulates NB synchronous RAMs, drives
// directed frames and checks writes and reads against a frame-level model.
module tb_neuron_bank_rotator;

  localparam int NB = 3;
  localparam int DP = 3;
  localparam int W  = 16;
  localparam int A  = 11;
  localparam int WD = W * (1 << DP);
  localparam int CW = $clog2(NB + 1);

  logic              CLK = 1'b0;
  logic              RST_N;
  logic [A-1:0]      frameLen;
  logic              wrValid;
  logic              wrReady;
  logic [WD-1:0]     wrData;
  logic              rdValid;
  logic              rdReady;
  logic [WD-1:0]     rdData;
  logic              rdKeep;
  logic [NB*A-1:0]   bankAddr;
  logic [NB-1:0]     bankWrite;
  logic [NB*WD-1:0]  bankIn;
  logic [NB*WD-1:0]  bankOut;
  logic [CW-1:0]     fullCount;
  logic              frameDone;

  neuron_bank_rotator #(.NB(NB), .depth(DP), .W(W), .A(A)) dut (
    .CLK(CLK), .RST_N(RST_N), .frameLen(frameLen),
    .wrValid(wrValid), .wrReady(wrReady), .wrData(wrData),
    .rdValid(rdValid), .rdReady(rdReady), .rdData(rdData), .rdKeep(rdKeep),
    .bankAddr(bankAddr), .bankWrite(bankWrite), .bankIn(bankIn), .bankOut(bankOut),
    .fullCount(fullCount), .frameDone(frameDone)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fdCount = 0;
  int mWrBank = 0;
  int mWrAddr = 0;
  logic [WD-1:0] expQ[$];
  int bankLog[$];
  int addrLog[$];
  int accCycles[$];
  int popCycles[$];
  logic [NB-1:0] expW;

  logic [WD-1:0] ram [NB][1<<A];

  task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Synchronous single-port RAMs, one-cycle read latency
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    for (int b = 0; b < NB; b++) begin
      if (bankWrite[b]) ram[b][bankAddr[b*A +: A]] <= bankIn[b*WD +: WD];
      bankOut[b*WD +: WD] <= ram[b][bankAddr[b*A +: A]];
    end
  end

  // Per-cycle compare: write strobes/addresses against frame-level bank model, read stream against queue
  always @(negedge CLK) begin
    if (!RST_N) begin
      mWrBank = 0;
      mWrAddr = 0;
    end else begin
      expW = '0;
      if (wrValid && wrReady) expW[mWrBank] = 1'b1;
      check("bankWrite", WD'(bankWrite), WD'(expW));
      if (wrValid && wrReady) begin
        check("wrAddr", WD'(bankAddr[mWrBank*A +: A]), WD'(mWrAddr));
        check("bankIn", bankIn[mWrBank*WD +: WD], wrData);
        bankLog.push_back(mWrBank);
        addrLog.push_back(int'(bankAddr[mWrBank*A +: A]));
        accCycles.push_back(cyc);
        if (mWrAddr == int'(frameLen)) begin
          mWrAddr = 0;
          mWrBank = (mWrBank + 1) % NB;
        end else begin
          mWrAddr = mWrAddr + 1;
        end
      end
      if (rdValid && rdReady) begin
        popCycles.push_back(cyc);
        if (expQ.size() == 0) check("rdExtra", rdData, WD'(0) - WD'(1) ^ rdData);
        else                  check("rdData", rdData, expQ.pop_front());
      end
      if (frameDone) fdCount++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic writeWord(input logic [WD-1:0] d);
    bit got = 0;
    wrData  = d;
    wrValid = 1'b1;
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge CLK);
      got = wrReady;
      @(posedge CLK);
      #1;
    end
    wrValid = 1'b0;
    if (!got) check("wrTimeout", WD'(0), WD'(1));
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(negedge CLK);
      n++;
    end
    check("drainTimeout", WD'(expQ.size()), WD'(0));
  endtask

  task automatic checkZero(input string tag);
    check({tag, "WrReady"}, WD'(wrReady), WD'(0));
    check({tag, "RdValid"}, WD'(rdValid), WD'(0));
    check({tag, "RdData"}, rdData, WD'(0));
    check({tag, "BankAddr"}, WD'(bankAddr), WD'(0));
    check({tag, "BankWrite"}, WD'(bankWrite), WD'(0));
    check({tag, "FullCount"}, WD'(fullCount), WD'(0));
    check({tag, "FrameDone"}, WD'(frameDone), WD'(0));
    for (int b = 0; b < NB; b++) check({tag, "BankIn"}, bankIn[b*WD +: WD], WD'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int fd0;
    int expBanks[4];
    RST_N = 1'b0; wrValid = 1'b0; wrData = '0; rdReady = 1'b0; rdKeep = 1'b0;
    frameLen = A'(3);
    #2;
    checkZero("rst");
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    @(negedge CLK);
    check("idleWrReady", WD'(wrReady), WD'(1));
    check("idleRdValid", WD'(rdValid), WD'(0));
    check("idleFullCount", WD'(fullCount), WD'(0));

    // Single frame 0x11..0x44, consumer always ready
    step();
    fd0 = fdCount; accCycles.delete(); popCycles.delete();
    rdReady = 1'b1;
    for (int i = 1; i <= 4; i++) expQ.push_back(WD'(i * 32'h11));
    for (int i = 1; i <= 4; i++) writeWord(WD'(i * 32'h11));
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t1Frames", WD'(fdCount - fd0), WD'(1));
    check("t1PopCount", WD'(popCycles.size()), WD'(4));
    if (popCycles.size() >= 4 && accCycles.size() >= 4) begin
      check("t1Latency", WD'(popCycles[0] - accCycles[3]), WD'(3));
      check("t1Back2Back", WD'(popCycles[3] - popCycles[0]), WD'(3));
    end
    check("t1FullCount", WD'(fullCount), WD'(0));
    check("t1WrReady", WD'(wrReady), WD'(1));

    // Three frames with the consumer stalled: all banks occupied
    step();
    fd0 = fdCount;
    rdReady = 1'b0;
    for (int i = 1; i <= 12; i++) expQ.push_back(WD'(32'h100 + i));
    for (int i = 1; i <= 12; i++) writeWord(WD'(32'h100 + i));
    repeat (2) @(negedge CLK);
    check("t2WrStall", WD'(wrReady), WD'(0));
    check("t2FullCount", WD'(fullCount), WD'(3));
    step();
    rdReady = 1'b1;
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t2Frames", WD'(fdCount - fd0), WD'(3));
    check("t2WrReady", WD'(wrReady), WD'(1));
    check("t2FullCountEnd", WD'(fullCount), WD'(0));

    // Consumer toggling ready while two frames stream through
    step();
    fd0 = fdCount;
    for (int i = 1; i <= 8; i++) expQ.push_back(WD'(32'h200 + i));
    fork
      begin
        for (int i = 1; i <= 8; i++) writeWord(WD'(32'h200 + i));
      end
      begin
        for (int k = 0; k < 40; k++) begin
          @(posedge CLK);
          #1 rdReady = (k % 2 == 0);
        end
      end
    join
    step();
    rdReady = 1'b1;
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t3Frames", WD'(fdCount - fd0), WD'(2));

    // Keep mode: one frame replayed, then released
    step();
    fd0 = fdCount;
    rdKeep = 1'b1;
    for (int p = 0; p < 2; p++)
      for (int i = 1; i <= 4; i++) expQ.push_back(WD'(32'h300 + i));
    for (int i = 1; i <= 4; i++) writeWord(WD'(32'h300 + i));
    for (int n = 0; n < 300 && expQ.size() > 4; n++) @(negedge CLK);
    step();
    rdKeep = 1'b0;
    @(negedge CLK);
    check("t4FullCountKeep", WD'(fullCount), WD'(1));
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t4Frames", WD'(fdCount - fd0), WD'(2));
    check("t4FullCountEnd", WD'(fullCount), WD'(0));

    // Reset mid-fill, then a fresh frame must land at bank0 address 0
    step();
    writeWord(WD'(32'h401));
    writeWord(WD'(32'h402));
    wrValid = 1'b1;
    wrData  = WD'(32'h403);
    RST_N   = 1'b0;
    expQ.delete();
    #2;
    checkZero("midRst");
    step();
    step();
    wrValid = 1'b0;
    RST_N   = 1'b1;
    bankLog.delete(); addrLog.delete();
    fd0 = fdCount;
    for (int i = 1; i <= 4; i++) expQ.push_back(WD'(32'h500 + i));
    for (int i = 1; i <= 4; i++) writeWord(WD'(32'h500 + i));
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t6Bank", WD'(bankLog.size() > 0 ? bankLog[0] : 99), WD'(0));
    check("t6Addr", WD'(addrLog.size() > 0 ? addrLog[0] : 99), WD'(0));
    check("t6Frames", WD'(fdCount - fd0), WD'(1));

    // Single-word frames after a clean reset: banks 0,1,2,0
    step();
    RST_N = 1'b0;
    step();
    RST_N = 1'b1;
    frameLen = '0;
    bankLog.delete();
    fd0 = fdCount;
    expBanks = '{0, 1, 2, 0};
    for (int i = 0; i < 4; i++) expQ.push_back(WD'(32'hA + i));
    for (int i = 0; i < 4; i++) writeWord(WD'(32'hA + i));
    waitDrain(300);
    repeat (3) @(negedge CLK);
    check("t5LogSize", WD'(bankLog.size()), WD'(4));
    for (int i = 0; i < 4; i++)
      check("t5Bank", WD'(bankLog.size() > i ? bankLog[i] : 99), WD'(expBanks[i]));
    check("t5Frames", WD'(fdCount - fd0), WD'(4));
    check("t5FullCount", WD'(fullCount), WD'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
